// File: rtl/dsam_channel_arbiter_if.sv
// Requester/encoder bundle for the dsam channel arbiter.
// The slave modport is the arbiter's view; the master modport is the environment's.
interface dsam_channel_arbiter_if #(
  parameter int DATA_WIDTH = 16,
  parameter int CHANNELS   = 4,
  parameter int CW         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
);
  logic [CHANNELS-1:0]            req_valid;
  logic [CHANNELS*DATA_WIDTH-1:0] req_data;
  logic [CHANNELS-1:0]            req_last;
  logic [CHANNELS-1:0]            req_ready;
  logic                           enc_valid;
  logic [DATA_WIDTH-1:0]          enc_data;
  logic [CW-1:0]                  enc_chan;
  logic                           enc_first;
  logic                           enc_ready;

  modport slave (
    input  req_valid, req_data, req_last, enc_ready,
    output req_ready, enc_valid, enc_data, enc_chan, enc_first
  );

  modport master (
    output req_valid, req_data, req_last, enc_ready,
    input  req_ready, enc_valid, enc_data, enc_chan, enc_first
  );
endinterface

// File: rtl/dsam_channel_arbiter.sv
// Round-robin arbiter sharing one dsam encoder between CHANNELS requesters.
// Grants lock for a burst, capped at MAX_BURST beats; beats are tagged with channel id.
module dsam_channel_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int CHANNELS   = 4,
  parameter int MAX_BURST  = 8
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  dsam_channel_arbiter_if.slave io_bus
);
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t                r_state;
  logic [CW-1:0]         r_rr_ptr;
  logic [CW-1:0]         r_grant;
  logic [BW-1:0]         r_beat_cnt;
  logic                  r_enc_valid;
  logic [DATA_WIDTH-1:0] r_enc_data;
  logic [CW-1:0]         r_enc_chan;
  logic                  r_enc_first;

  logic                  w_any;
  logic [CW-1:0]         w_sel;
  int                    w_idx;
  logic                  w_open;
  logic                  w_fire;
  logic                  w_last;
  logic                  w_release;
  logic [DATA_WIDTH-1:0] w_data;
  logic [CHANNELS-1:0]   w_req_ready;
  logic [CW-1:0]         w_next_ptr;

  // Scan downward so the channel closest to rr_ptr is the last writer.
  always_comb begin
    w_any = 1'b0;
    w_sel = '0;
    w_idx = 0;
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      w_idx = (int'(r_rr_ptr) + k) % CHANNELS;
      if (io_bus.req_valid[w_idx]) begin
        w_any = 1'b1;
        w_sel = CW'(w_idx);
      end
    end
  end

  assign w_open = (r_state == S_GRANT) &&
                  (!r_enc_valid || io_bus.enc_ready);

  always_comb begin
    w_req_ready = '0;
    w_req_ready[r_grant] = w_open;
  end

  assign w_fire = w_open && io_bus.req_valid[r_grant];
  assign w_last = io_bus.req_last[r_grant];
  assign w_data =
    io_bus.req_data[int'(r_grant)*DATA_WIDTH +: DATA_WIDTH];

  assign w_release = w_fire &&
    (w_last || (r_beat_cnt == BW'(MAX_BURST - 1)));

  assign w_next_ptr = (r_grant == CW'(CHANNELS - 1)) ?
                      '0 : r_grant + 1'b1;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state     <= S_IDLE;
      r_rr_ptr    <= '0;
      r_grant     <= '0;
      r_beat_cnt  <= '0;
      r_enc_valid <= 1'b0;
      r_enc_data  <= '0;
      r_enc_chan  <= '0;
      r_enc_first <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_grant    <= w_sel;
            r_beat_cnt <= '0;
            r_state    <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (w_fire) r_beat_cnt <= r_beat_cnt + 1'b1;
          if (w_release) begin
            r_state  <= S_IDLE;
            r_rr_ptr <= w_next_ptr;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      // Output slot: load on transfer, else drain on accept, else hold.
      if (w_fire) begin
        r_enc_valid <= 1'b1;
        r_enc_data  <= w_data;
        r_enc_chan  <= r_grant;
        r_enc_first <= (r_beat_cnt == '0);
      end else if (r_enc_valid && io_bus.enc_ready) begin
        r_enc_valid <= 1'b0;
      end
    end
  end

  assign io_bus.req_ready = w_req_ready;
  assign io_bus.enc_valid = r_enc_valid;
  assign io_bus.enc_data  = r_enc_data;
  assign io_bus.enc_chan  = r_enc_chan;
  assign io_bus.enc_first = r_enc_first;
endmodule
